// File: rtl/imem_dmem_arbiter_if.sv
// ============================================================================
// imem_dmem_arbiter_if : request/response bundle between the fetch and data
//                        requesters, the arbiter and the unified memory port.
// Optional macro ARB_PERF_CNT_EN adds the perf_conflict/perf_starve counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface imem_dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  m_req;
    logic                  m_we;
    logic [DATA_W/8-1:0]   m_wstrb;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic                  m_gnt;
    logic                  m_rvalid;
    logic [DATA_W-1:0]     m_rdata;

    logic                  busy;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]           perf_conflict;
    logic [31:0]           perf_starve;
`endif

    // Arbiter view: owns the grants, responses and the memory request side.
    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_wstrb, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_wstrb, m_addr, m_wdata,
        input  m_gnt, m_rvalid, m_rdata,
        output busy
`ifdef ARB_PERF_CNT_EN
        , output perf_conflict, perf_starve
`endif
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_wstrb, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_wstrb, m_addr, m_wdata,
        output m_gnt, m_rvalid, m_rdata,
        input  busy
`ifdef ARB_PERF_CNT_EN
        , input perf_conflict, perf_starve
`endif
    );
endinterface

`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
// ============================================================================
// imem_dmem_arbiter : shares one memory port between instruction fetch and
//                     data access; data wins unless fetch has starved.
// Optional macro ARB_PERF_CNT_EN adds conflict/starvation event counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    imem_dmem_arbiter_if.master   bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    logic                owner_q,    owner_d;      // 1 = data side
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                m_req_q,    m_req_d;
    logic                m_we_q,     m_we_d;
    logic [STRB_W-1:0]   m_wstrb_q,  m_wstrb_d;
    logic [ADDR_W-1:0]   m_addr_q,   m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q,  m_wdata_d;

    logic w_starved;
    logic w_if_win;
    logic w_accept;
    logic w_if_gnt;
    logic w_d_gnt;
    logic w_resp;

    assign w_starved = (wait_cnt_q >= WAIT_W'(MAX_WAIT));
    assign w_if_win  = bus.if_req && (!bus.d_req || w_starved);
    // A response cycle doubles as an accept slot so back-to-back traffic has no bubble.
    assign w_accept  = ((state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.m_rvalid))
                       && (bus.if_req || bus.d_req);
    assign w_if_gnt  = rst_n && w_accept && w_if_win;
    assign w_d_gnt   = rst_n && w_accept && !w_if_win;
    assign w_resp    = rst_n && (state_q == ST_RESP) && bus.m_rvalid;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_wstrb_d  = m_wstrb_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            ST_IDLE: ;
            ST_REQ: begin
                if (bus.m_gnt) begin
                    m_req_d = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.m_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_accept) begin
            state_d = ST_REQ;
            m_req_d = 1'b1;
            owner_d = !w_if_win;
            if (w_if_win) begin
                m_we_d    = 1'b0;
                m_wstrb_d = '0;
                m_addr_d  = bus.if_addr;
                m_wdata_d = '0;
            end else begin
                m_we_d    = bus.d_we;
                m_wstrb_d = bus.d_wstrb;
                m_addr_d  = bus.d_addr;
                m_wdata_d = bus.d_wdata;
            end
        end

        if (!bus.if_req || w_if_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != {WAIT_W{1'b1}}) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            wait_cnt_q <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_wstrb_q  <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_wstrb_q  <= m_wstrb_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
        end
    end

    assign bus.if_gnt    = w_if_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.if_rvalid = w_resp && !owner_q;
    assign bus.d_rvalid  = w_resp && owner_q;
    assign bus.if_rdata  = bus.m_rdata;
    assign bus.d_rdata   = bus.m_rdata;
    assign bus.m_req     = m_req_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_wstrb   = m_wstrb_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.busy      = (state_q != ST_IDLE);

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_conflict_q;
    logic [31:0] perf_starve_q;
    logic        w_conflict;

    assign w_conflict = w_accept && bus.if_req && bus.d_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_conflict_q <= '0;
            perf_starve_q   <= '0;
        end else begin
            if (w_conflict) begin
                perf_conflict_q <= perf_conflict_q + 32'd1;
            end
            // Fetch only beats a competing data request through starvation.
            if (w_conflict && w_starved) begin
                perf_starve_q <= perf_starve_q + 32'd1;
            end
        end
    end

    assign bus.perf_conflict = perf_conflict_q;
    assign bus.perf_starve   = perf_starve_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
// ============================================================================
// tb_imem_dmem_arbiter : directed scenarios plus a randomized run checked
//                        against a transaction-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imem_dmem_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
    localparam int WAIT_W   = 3;
    localparam int SAT      = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imem_dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic clear_inputs();
        bus.if_req  = 1'b0; bus.if_addr = '0;
        bus.d_req   = 1'b0; bus.d_we    = 1'b0; bus.d_wstrb = '0;
        bus.d_addr  = '0;   bus.d_wdata = '0;
        bus.m_gnt   = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.if_req = 1'b1; bus.d_req = 1'b1; bus.m_gnt = 1'b1; bus.m_rvalid = 1'b1;
        #1;
        checks++;
        if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gnt_rvalid got=%b exp=0000",
                     {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.m_req, bus.m_we, bus.m_wstrb, bus.m_addr, bus.m_wdata, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_regs got=%h exp=0",
                     {bus.m_req, bus.m_we, bus.m_wstrb, bus.m_addr, bus.m_wdata, bus.busy});
        end
`ifdef ARB_PERF_CNT_EN
        checks++;
        if ({bus.perf_conflict, bus.perf_starve} !== 64'd0) begin
            errors++;
            $display("FAIL reset_perf got=%h exp=0", {bus.perf_conflict, bus.perf_starve});
        end
`endif
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        apply_reset();
        @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 32'h100; #1;
        checks++;
        if ({bus.if_gnt, bus.d_gnt, bus.busy} !== 3'b100) begin
            errors++; $display("FAIL sf_grant got=%b exp=100", {bus.if_gnt, bus.d_gnt, bus.busy});
        end
        @(negedge clk); bus.if_req = 1'b0; bus.m_gnt = 1'b1; #1;
        checks++;
        if ({bus.m_req, bus.m_we, bus.busy, bus.m_addr} !== {3'b101, 32'h100}) begin
            errors++; $display("FAIL sf_mreq got=%h exp=%h",
                               {bus.m_req, bus.m_we, bus.busy, bus.m_addr}, {3'b101, 32'h100});
        end
        @(negedge clk); bus.m_gnt = 1'b0; #1;
        checks++;
        if ({bus.m_req, bus.if_rvalid, bus.busy} !== 3'b001) begin
            errors++; $display("FAIL sf_wait got=%b exp=001", {bus.m_req, bus.if_rvalid, bus.busy});
        end
        @(negedge clk); bus.m_rvalid = 1'b1; bus.m_rdata = 32'hDEADBEEF; #1;
        checks++;
        if ({bus.if_rvalid, bus.d_rvalid, bus.if_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            errors++; $display("FAIL sf_resp got=%h exp=%h",
                               {bus.if_rvalid, bus.d_rvalid, bus.if_rdata}, {2'b10, 32'hDEADBEEF});
        end
        @(negedge clk); bus.m_rvalid = 1'b0; #1;
        checks++;
        if ({bus.busy, bus.if_rvalid} !== 2'b00) begin
            errors++; $display("FAIL sf_idle got=%b exp=00", {bus.busy, bus.if_rvalid});
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000; bus.d_wdata = 32'hFFFFFFFF; bus.d_wstrb = 4'hF;
        #1;
        checks++;
        if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin
            errors++; $display("FAIL cf_dwins got=%b exp=01", {bus.if_gnt, bus.d_gnt});
        end
        @(negedge clk); bus.d_req = 1'b0; bus.m_gnt = 1'b1; #1;
        checks++;
        if ({bus.m_req, bus.m_we, bus.if_gnt, bus.m_addr} !== {3'b100, 32'h2000}) begin
            errors++; $display("FAIL cf_dload got=%h exp=%h",
                               {bus.m_req, bus.m_we, bus.if_gnt, bus.m_addr}, {3'b100, 32'h2000});
        end
        @(negedge clk); bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h11223344; #1;
        checks++;
        if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.d_rdata} !== {4'b1001, 32'h11223344}) begin
            errors++; $display("FAIL cf_b2b got=%h exp=%h",
                               {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.d_rdata},
                               {4'b1001, 32'h11223344});
        end
        @(negedge clk); bus.if_req = 1'b0; bus.m_rvalid = 1'b0; bus.m_gnt = 1'b1; #1;
        checks++;
        if ({bus.m_req, bus.m_we, bus.busy, bus.m_addr} !== {3'b101, 32'h300}) begin
            errors++; $display("FAIL cf_fetch got=%h exp=%h",
                               {bus.m_req, bus.m_we, bus.busy, bus.m_addr}, {3'b101, 32'h300});
        end
        @(negedge clk); bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; #1;
        checks++;
        if ({bus.if_rvalid, bus.d_rvalid} !== 2'b10) begin
            errors++; $display("FAIL cf_fresp got=%b exp=10", {bus.if_rvalid, bus.d_rvalid});
        end
        @(negedge clk); bus.m_rvalid = 1'b0; #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL cf_idle got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_starvation();
        apply_reset();
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h400;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h3000;
        #1;
        checks++;
        if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin
            errors++; $display("FAIL st_acc1 got=%b exp=01", {bus.if_gnt, bus.d_gnt});
        end
        @(negedge clk); bus.m_gnt = 1'b1; bus.d_addr = 32'h3004; #1;
        @(negedge clk); bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; #1;
        checks++;
        if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin
            errors++; $display("FAIL st_acc2 got=%b exp=01", {bus.if_gnt, bus.d_gnt});
        end
        @(negedge clk); bus.m_rvalid = 1'b0; bus.m_gnt = 1'b1; bus.d_addr = 32'h3008; #1;
        checks++;
        if (bus.m_addr !== 32'h3004) begin
            errors++; $display("FAIL st_addr2 got=%h exp=3004", bus.m_addr);
        end
        @(negedge clk); bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; #1;
        checks++;
        if ({bus.if_gnt, bus.d_gnt} !== 2'b10) begin
            errors++; $display("FAIL st_ifwins got=%b exp=10", {bus.if_gnt, bus.d_gnt});
        end
        @(negedge clk); bus.if_addr = 32'h404; bus.m_rvalid = 1'b0; bus.m_gnt = 1'b1; #1;
        checks++;
        if ({bus.m_req, bus.m_we, bus.m_addr} !== {2'b10, 32'h400}) begin
            errors++; $display("FAIL st_fetch got=%h exp=%h", {bus.m_req, bus.m_we, bus.m_addr}, {2'b10, 32'h400});
        end
`ifdef ARB_PERF_CNT_EN
        checks++;
        if ({bus.perf_conflict, bus.perf_starve} !== {32'd3, 32'd1}) begin
            errors++; $display("FAIL st_perf got=%0d/%0d exp=3/1", bus.perf_conflict, bus.perf_starve);
        end
`endif
        @(negedge clk); bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; #1;
        checks++;
        if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid} !== 3'b011) begin
            errors++; $display("FAIL st_cleared got=%b exp=011", {bus.if_gnt, bus.d_gnt, bus.if_rvalid});
        end
    endtask

    task automatic test_store();
        apply_reset();
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_wstrb = 4'h3; bus.d_wdata = 32'h0000ABCD; bus.d_addr = 32'h40;
        #1;
        checks++;
        if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin
            errors++; $display("FAIL sd_gnt got=%b exp=01", {bus.if_gnt, bus.d_gnt});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); bus.d_req = 1'b0; bus.m_gnt = (i == 3); #1;
            checks++;
            if ({bus.m_req, bus.m_we, bus.m_wstrb, bus.m_addr, bus.m_wdata} !==
                {1'b1, 1'b1, 4'h3, 32'h40, 32'h0000ABCD}) begin
                errors++; $display("FAIL sd_hold%0d got=%h exp=%h", i,
                                   {bus.m_req, bus.m_we, bus.m_wstrb, bus.m_addr, bus.m_wdata},
                                   {1'b1, 1'b1, 4'h3, 32'h40, 32'h0000ABCD});
            end
        end
        @(negedge clk); bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; #1;
        checks++;
        if ({bus.m_req, bus.if_rvalid, bus.d_rvalid} !== 3'b001) begin
            errors++; $display("FAIL sd_ack got=%b exp=001", {bus.m_req, bus.if_rvalid, bus.d_rvalid});
        end
        @(negedge clk); bus.m_rvalid = 1'b0; #1;
    endtask

    task automatic test_reset_midop();
        apply_reset();
        @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 32'h500; #1;
        @(negedge clk); bus.if_req = 1'b0; bus.m_gnt = 1'b1; #1;
        @(negedge clk); bus.m_gnt = 1'b0; rst_n = 1'b0;
        bus.if_req = 1'b1; bus.d_req = 1'b1; bus.m_rvalid = 1'b1; #1;
        checks++;
        if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid} !== 4'b0000) begin
            errors++; $display("FAIL rm_gated got=%b exp=0000",
                               {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid});
        end
        @(negedge clk); rst_n = 1'b1; bus.if_req = 1'b0; bus.d_req = 1'b0; bus.m_rvalid = 1'b1; #1;
        checks++;
        if ({bus.m_req, bus.m_we, bus.m_wstrb, bus.m_addr, bus.m_wdata, bus.busy,
             bus.if_rvalid, bus.d_rvalid} !== '0) begin
            errors++; $display("FAIL rm_abandon got=%h exp=0",
                               {bus.m_req, bus.m_we, bus.m_wstrb, bus.m_addr, bus.m_wdata, bus.busy,
                                bus.if_rvalid, bus.d_rvalid});
        end
        @(negedge clk); bus.m_rvalid = 1'b0;
    endtask

    // Reference: phase 0 = free, 1 = request posted, 2 = awaiting response.
    task automatic test_random();
        int          ph = 0, own = 0, wc = 0, rv_cnt = 0, n_conf = 0, n_starve = 0;
        bit          rv_pend = 0, ifp = 0, dp = 0, rv, acc, ifwin;
        logic [31:0] ia = '0, da = '0, dwd = '0;
        logic [3:0]  dst = '0;
        logic        dwe = 1'b0;
        bit          e_mreq = 0, e_mwe = 0, e_wd_chk = 1;
        logic [3:0]  e_mstrb = '0;
        logic [31:0] e_maddr = '0, e_mwdata = '0;
        logic [4:0]  e_flags;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!ifp) begin
                if ($urandom_range(0, 1) == 1) begin ifp = 1; ia = $urandom; end
            end else if ($urandom_range(0, 19) == 0) ifp = 0;
            if (!dp) begin
                if ($urandom_range(0, 3) != 0) begin
                    dp = 1; da = $urandom; dwd = $urandom; dst = 4'($urandom); dwe = 1'($urandom);
                end
            end else if ($urandom_range(0, 19) == 0) dp = 0;
            bus.if_req = ifp; bus.if_addr = ia;
            bus.d_req = dp; bus.d_addr = da; bus.d_wdata = dwd; bus.d_wstrb = dst; bus.d_we = dwe;
            bus.m_gnt = 1'($urandom_range(0, 1));
            rv = rv_pend && (rv_cnt == 0);
            if (!rv_pend && $urandom_range(0, 15) == 0) rv = 1;
            bus.m_rvalid = rv; bus.m_rdata = $urandom;
            #1;
            acc   = (ph == 0 || (ph == 2 && rv)) && (ifp || dp);
            ifwin = ifp && (!dp || wc >= MAX_WAIT);
            e_flags = {acc && ifwin, acc && !ifwin, ph == 2 && rv && own == 0,
                       ph == 2 && rv && own == 1, ph != 0};
            checks++;
            if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.busy} !== e_flags) begin
                errors++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc,
                                   {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.busy}, e_flags);
            end
            checks++;
            if ({bus.m_req, bus.m_we, bus.m_wstrb, bus.m_addr} !== {e_mreq, e_mwe, e_mstrb, e_maddr} ||
                (e_wd_chk && bus.m_wdata !== e_mwdata) ||
                bus.if_rdata !== bus.m_rdata || bus.d_rdata !== bus.m_rdata) begin
                errors++; $display("FAIL rnd_bus cyc=%0d got=%h/%h exp=%h/%h", cyc,
                                   {bus.m_req, bus.m_we, bus.m_wstrb, bus.m_addr}, bus.m_wdata,
                                   {e_mreq, e_mwe, e_mstrb, e_maddr}, e_mwdata);
            end
            if (acc && ifp && dp) begin
                n_conf++;
                if (ifwin) n_starve++;
            end
            if (!ifp || (acc && ifwin)) wc = 0;
            else if (wc < SAT) wc++;
            if (rv_pend) begin
                if (rv_cnt == 0) rv_pend = 0;
                else rv_cnt--;
            end
            if (acc) begin
                ph = 1; e_mreq = 1; own = ifwin ? 0 : 1;
                e_maddr = ifwin ? ia : da;
                e_mwe = ifwin ? 1'b0 : dwe;
                e_mstrb = ifwin ? 4'h0 : dst;
                e_mwdata = dwd; e_wd_chk = !ifwin;
                if (ifwin) ifp = 0; else dp = 0;
            end else if (ph == 1 && bus.m_gnt) begin
                ph = 2; e_mreq = 0; rv_pend = 1; rv_cnt = $urandom_range(0, 2);
            end else if (ph == 2 && rv) begin
                ph = 0;
            end
        end
`ifdef ARB_PERF_CNT_EN
        @(negedge clk);
        checks++;
        if ({bus.perf_conflict, bus.perf_starve} !== {32'(n_conf), 32'(n_starve)}) begin
            errors++; $display("FAIL rnd_perf got=%0d/%0d exp=%0d/%0d",
                               bus.perf_conflict, bus.perf_starve, n_conf, n_starve);
        end
`endif
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_conflict();
        test_starvation();
        test_store();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares the core's single memory/bus port between two requesters: instruction fetch (IF) and data load/store (D).
- Sits between the fetch/decode and memory/writeback stages and the unified memory interface.
- Allows at most one transaction outstanding at a time.
- D has priority by default; a starvation counter guarantees forward progress for IF.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (strobe width = DATA_W/8)
MAX_WAIT, 4, consecutive denied IF cycles before IF is forced to win
WAIT_W, 3, width of starvation counter (must hold MAX_WAIT)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, synchronous, active-low
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted (1-cycle pulse)
if_rvalid  out  1  fetch response valid (1-cycle pulse)
if_rdata  out  DATA_W  fetch response data
d_req  in  1  data request; held with payload stable until d_gnt
d_we  in  1  1 = store, 0 = load
d_wstrb  in  DATA_W/8  byte strobes for stores
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted (1-cycle pulse)
d_rvalid  out  1  data response/ack valid (1-cycle pulse)
d_rdata  out  DATA_W  load data
m_req  out  1  memory request (registered)
m_we  out  1  memory write enable (registered)
m_wstrb  out  DATA_W/8  memory strobes (registered)
m_addr  out  ADDR_W  memory address (registered)
m_wdata  out  DATA_W  memory write data (registered)
m_gnt  in  1  memory accepted request
m_rvalid  in  1  memory response; one pulse per accepted request, including writes
m_rdata  in  DATA_W  memory read data
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, owner=IF, wait_cnt=0, m_req/m_we=0, m_wstrb/m_addr/m_wdata=0. All gnt/rvalid outputs are 0 while rst_n=0.
- FSM states: IDLE, REQ, RESP.
- Accept condition: "accept" = state==IDLE, or state==RESP with m_rvalid=1, and (if_req or d_req).
- Arbitration on accept:
  - Winner=IF if if_req and (!d_req or wait_cnt>=MAX_WAIT); otherwise winner=D.
  - Winner's gnt pulses combinationally that cycle. Loser's gnt stays 0.
  - Payload is latched into m_* registers and owner is recorded; next state=REQ, m_req=1.
  - IF transactions drive m_we=0 and m_wstrb=0.
- REQ: m_req held with stable payload until m_gnt=1. On m_gnt, m_req<=0 next cycle and state=RESP.
- RESP:
  - On m_rvalid: owner's rvalid=1 (combinational). Both rdata outputs always mirror m_rdata.
  - Then: if a new request is present, accept it (back-to-back, no idle bubble); otherwise go to IDLE.
- m_rvalid in IDLE or REQ is ignored; no rvalid output is generated.
- Throughput: 1 transaction per (2 + memory latency) cycles minimum. Grant-to-m_req latency is 1 cycle.
- Starvation counter (wait_cnt):
  - Increments (saturating at 2^WAIT_W-1) each cycle if_req=1 and if_gnt=0.
  - Clears when if_gnt=1 or if_req=0.
- Simultaneous if_req and d_req with wait_cnt<MAX_WAIT: D wins. At wait_cnt>=MAX_WAIT: IF wins.
- Requester dropping req before gnt: legal; no transaction is issued for it.
- Reset mid-transaction: outstanding transaction is abandoned. A late m_rvalid after reset is not forwarded.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: adds outputs perf_conflict out 32 and perf_starve out 32, both reset to 0 and wrapping modulo 2^32.
  - perf_conflict counts accept cycles with both if_req and d_req high.
  - perf_starve counts accepts where IF won because of wait_cnt.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single fetch: if_req=1, addr=0x100, memory m_gnt same cycle, rvalid 2 cycles later with 0xDEADBEEF.
  -> if_gnt at cycle 0; m_req/m_addr=0x100 at cycle 1; if_rvalid with if_rdata=0xDEADBEEF; busy back to 0.
- Conflict: if_req and d_req (load 0x2000) together.
  -> d_gnt first, m_we=0, m_addr=0x2000; IF granted at the m_rvalid cycle of D, back-to-back.
- Starvation: if_req held high while d_req is reasserted every accept, MAX_WAIT=4.
  -> IF wins the accept where wait_cnt reaches 4; wait_cnt returns to 0.
- Store: d_we=1, d_wstrb=0x3, d_wdata=0x0000ABCD, m_gnt delayed 3 cycles.
  -> m_req/payload held stable for 3 cycles; d_rvalid on m_rvalid; if_rvalid stays 0.
- Reset mid-op: rst_n=0 while in RESP, then m_rvalid arrives after release.
  -> all outputs 0, state IDLE, no rvalid forwarded.
- ARB_PERF_CNT_EN: 3 conflicting accepts, 1 starvation win -> perf_conflict=3, perf_starve=1.
